mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single main-memory request/response port between the instruction cache and the data cache miss engines.
- Grants one requester at a time with round-robin on contention.
- Holds the grant for the full transaction: single word, or multi-beat line fill.
- Forwards per-beat responses to the granted requester only, and bounds every transaction with a timeout.
- Sits between both cache_FSM instances and the memory model/controller.

Parameters:
- BEATS_LINE, 2, number of mem_resp.ready beats that complete a line-fill (op 2'b10) transaction.
- TIMEOUT_CYCLES, 255, maximum cycles in BUSY without a mem_resp.ready beat before abort.
- CNT_W, 8, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous and active-high.
- icache_req  input  request_type  instruction-cache memory request (addr, data, op, valid).
- icache_resp  output  response_type  response to instruction cache (data, ready).
- dcache_req  input  request_type  data-cache memory request.
- dcache_resp  output  response_type  response to data cache.
- mem_req  output  request_type  request to main memory.
- mem_resp  input  response_type  main-memory response; ready marks one valid beat.
- grant  output  2  one-hot current owner: bit0 icache, bit1 dcache; 2'b00 when idle.
- timeout  output  1  one-cycle pulse when a transaction is aborted by timeout.

Behaviour:
- Op encoding: 2'b00 word read (1 beat), 2'b01 write (1 beat), 2'b10 line fill (BEATS_LINE beats); 2'b11 is treated as 1 beat.
- States:
  - IDLE: no owner.
  - BUSY: owner granted, transaction in flight.
  - DONE: one-cycle turnaround; no grant is issued, which absorbs the requester dropping valid.
- Reset (async) drives the following:
  - state IDLE, grant 2'b00, mem_req all-zero (valid 0).
  - icache_resp/dcache_resp all-zero, timeout 0.
  - beat and timeout counters 0, last_owner = DCACHE, so icache wins the first tie.
- IDLE, cycle N, any req.valid=1:
  - Pick the owner. Single requester wins. If both are valid, the requester not equal to last_owner wins.
  - Register the owner's request into mem_req, latch the beat target from op, and go to BUSY.
  - mem_req.valid=1 and grant become visible at N+1.
- BUSY:
  - mem_req is held stable from the latched copy. Requester input changes are ignored.
  - Owner's resp is combinationally mem_resp (data, ready) in the same cycle. The non-owner resp is all-zero.
  - Each mem_resp.ready increments the beat count and clears the timeout counter.
  - On the final beat, mem_req.valid drops the next cycle, last_owner is set to owner, and the state goes to DONE.
- Timeout: timeout counter increments in BUSY on every cycle without a ready beat. On reaching TIMEOUT_CYCLES, for one cycle:
  - Owner resp: ready=1, data=0.
  - timeout=1.
  - mem_req.valid drops next cycle, last_owner updates, state goes to DONE.
- DONE: grant 2'b00, all resps zero, then IDLE the next cycle. Earliest re-grant is 2 cycles after the final beat.
- mem_resp.ready in IDLE or DONE: ignored, and forwarded to nobody.
- Final beat and timeout threshold in the same cycle: treated as normal completion; no timeout pulse.
- Non-owner valid held throughout BUSY: that requester is served next, guaranteed by round-robin (no starvation).
- Reset mid-transaction: everything aborts immediately with no response to the owner. Caches are reset by the same rst.

Decomposition:
- Shared package (cache_data_structs):
  - existing request_type and response_type.
  - new localparams OP_READ=2'b00, OP_WRITE=2'b01, OP_LINE=2'b10.
  - enum arb_state_t {ARB_IDLE, ARB_BUSY, ARB_DONE}.
  - enum requester_t {REQ_ICACHE, REQ_DCACHE}.
- Sub-module rr_pick2: purely combinational two-way round-robin selection. Inputs: two valids and last_owner. Outputs: winner and any_valid. Reused by later multi-port memory work.

Test Plan:
- Icache-only word read at addr 0x100: mem_req.valid and grant=01 appear the cycle after icache_req.valid. Memory returns ready with data 0xDEADBEEF after 3 cycles. icache_resp={0xDEADBEEF,1} for exactly 1 cycle, dcache_resp stays 0, then DONE, then IDLE.
- Dcache line fill, op 10, addr 0x208, BEATS_LINE=2: two ready beats with data 0x11111111 and 0x22222222 are both forwarded to dcache_resp. mem_req.addr stays 0x208 throughout. grant=10 until after the second beat.
- Both valid in the same IDLE cycle after reset: icache is granted first. Dcache's held valid is granted 2 cycles after icache's final beat. Next simultaneous contention goes to icache (alternation verified over 4 rounds).
- No mem_resp.ready for 255 cycles in BUSY: owner resp={0,1} and timeout=1 for one cycle, then DONE and IDLE. The ready=1 injected in DONE is not forwarded.
- rst asserted asynchronously mid line-fill after beat 1: mem_req.valid, grant and resps go to 0 without waiting for clk. After release, the first contention grants icache.

Source files
------------

// File: rtl/cache_data_structs.sv
// Shared cache/memory bus payloads and arbiter enums.
package cache_data_structs;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic [1:0]        op;
      logic              valid;
   } request_type;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              ready;
   } response_type;

   localparam logic [1:0] OP_READ  = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_LINE  = 2'b10;

   typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_DONE} arb_state_t;
   typedef enum logic {REQ_ICACHE, REQ_DCACHE} requester_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: on a tie the requester that did not own last wins.
module rr_pick2
   import cache_data_structs::*;
(
   input  logic       valid0,
   input  logic       valid1,
   input  requester_t last_owner,
   output requester_t winner,
   output logic       any_valid
);

   always_comb begin
      any_valid = valid0 | valid1;
      winner    = REQ_ICACHE;
      if (valid0 && valid1)
         winner = (last_owner == REQ_ICACHE) ? REQ_DCACHE : REQ_ICACHE;
      else if (valid1)
         winner = REQ_DCACHE;
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the main-memory port between icache and dcache miss engines,
// holding the grant for a whole transaction and bounding it with a timeout.
module mem_port_arbiter
   import cache_data_structs::*;
#(
   parameter int unsigned BEATS_LINE     = 2,
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned CNT_W          = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  request_type  icache_req,
   output response_type icache_resp,
   input  request_type  dcache_req,
   output response_type dcache_resp,
   output request_type  mem_req,
   input  response_type mem_resp,
   output logic [1:0]   grant,
   output logic         timeout
);

   localparam int unsigned BEAT_W = $clog2(BEATS_LINE + 1);

   arb_state_t        state;
   requester_t        owner;
   requester_t        last_owner;
   logic [BEAT_W-1:0] beat_cnt;
   logic [BEAT_W-1:0] beat_target;
   logic [CNT_W-1:0]  tmo_cnt;

   requester_t   winner;
   logic         any_valid;
   request_type  sel_req;
   logic         busy;
   logic         final_beat;
   logic         abort;
   response_type fwd_resp;

   rr_pick2 u_pick (
      .valid0     (icache_req.valid),
      .valid1     (dcache_req.valid),
      .last_owner (last_owner),
      .winner     (winner),
      .any_valid  (any_valid)
   );

   // A ready beat on the abort threshold completes normally, so abort needs !ready.
   always_comb begin
      sel_req    = (winner == REQ_DCACHE) ? dcache_req : icache_req;
      busy       = (state == ARB_BUSY);
      final_beat = busy && mem_resp.ready && (beat_cnt == beat_target - BEAT_W'(1));
      abort      = busy && !mem_resp.ready && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES));
      timeout    = abort;
      fwd_resp   = mem_resp;
      if (abort) begin
         fwd_resp.data  = '0;
         fwd_resp.ready = 1'b1;
      end
      icache_resp = (busy && owner == REQ_ICACHE) ? fwd_resp : '0;
      dcache_resp = (busy && owner == REQ_DCACHE) ? fwd_resp : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ARB_IDLE;
         owner       <= REQ_ICACHE;
         last_owner  <= REQ_DCACHE;
         grant       <= 2'b00;
         mem_req     <= '0;
         beat_cnt    <= '0;
         beat_target <= '0;
         tmo_cnt     <= '0;
      end else begin
         case (state)
            ARB_IDLE: begin
               if (any_valid) begin
                  owner       <= winner;
                  mem_req     <= sel_req;
                  grant       <= (winner == REQ_DCACHE) ? 2'b10 : 2'b01;
                  beat_target <= (sel_req.op == OP_LINE) ? BEAT_W'(BEATS_LINE) : BEAT_W'(1);
                  beat_cnt    <= '0;
                  tmo_cnt     <= '0;
                  state       <= ARB_BUSY;
               end
            end
            ARB_BUSY: begin
               if (final_beat || abort) begin
                  mem_req    <= '0;
                  grant      <= 2'b00;
                  last_owner <= owner;
                  state      <= ARB_DONE;
               end else if (mem_resp.ready) begin
                  beat_cnt <= beat_cnt + BEAT_W'(1);
                  tmo_cnt  <= '0;
               end else begin
                  tmo_cnt <= tmo_cnt + CNT_W'(1);
               end
            end
            ARB_DONE: state <= ARB_IDLE;
            default:  state <= ARB_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed table-driven bench for mem_port_arbiter plus multi-cycle corner sequences.
module tb_mem_port_arbiter;
   import cache_data_structs::*;

   logic         clk = 1'b0;
   logic         rst;
   request_type  icache_req, dcache_req, mem_req;
   response_type icache_resp, dcache_resp, mem_resp;
   logic [1:0]   grant;
   logic         timeout;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_port_arbiter dut (
      .clk         (clk),
      .rst         (rst),
      .icache_req  (icache_req),
      .icache_resp (icache_resp),
      .dcache_req  (dcache_req),
      .dcache_resp (dcache_resp),
      .mem_req     (mem_req),
      .mem_resp    (mem_resp),
      .grant       (grant),
      .timeout     (timeout)
   );

   typedef struct {
      logic        ic_v;  logic [1:0] ic_op; logic [31:0] ic_addr;
      logic        dc_v;  logic [1:0] dc_op; logic [31:0] dc_addr;
      logic        rdy;   logic [31:0] rdata;
      logic [1:0]  e_grant; logic e_mv; logic [31:0] e_maddr;
      logic [31:0] e_icd; logic e_icr; logic [31:0] e_dcd; logic e_dcr;
      logic        e_to;
   } vec_t;

   vec_t vecs[23];

   function automatic vec_t mk(logic icv, logic [1:0] icop, logic [31:0] ica,
                               logic dcv, logic [1:0] dcop, logic [31:0] dca,
                               logic r, logic [31:0] rd,
                               logic [1:0] eg, logic emv, logic [31:0] ema,
                               logic [31:0] eicd, logic eicr, logic [31:0] edcd, logic edcr,
                               logic eto);
      vec_t v;
      v.ic_v = icv; v.ic_op = icop; v.ic_addr = ica;
      v.dc_v = dcv; v.dc_op = dcop; v.dc_addr = dca;
      v.rdy = r; v.rdata = rd;
      v.e_grant = eg; v.e_mv = emv; v.e_maddr = ema;
      v.e_icd = eicd; v.e_icr = eicr; v.e_dcd = edcd; v.e_dcr = edcr;
      v.e_to = eto;
      return v;
   endfunction

   function automatic response_type mkr(logic [31:0] d, logic r);
      response_type x;
      x.data  = d;
      x.ready = r;
      return x;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic icv, input logic [1:0] icop, input logic [31:0] ica,
                        input logic dcv, input logic [1:0] dcop, input logic [31:0] dca,
                        input logic r, input logic [31:0] rd);
      icache_req = '{addr: ica, data: 32'h0, op: icop, valid: icv};
      dcache_req = '{addr: dca, data: 32'h0, op: dcop, valid: dcv};
      mem_resp   = mkr(rd, r);
   endtask

   initial begin
      int n;
      bit found;
      bit bad;
      logic [1:0] exp_g;
      rst = 1'b1;
      drive(0, 2'b00, 0, 0, 2'b00, 0, 0, 0);

      // icache word read, DONE/IDLE ready ignored
      vecs[0]  = mk(1, 2'b00, 32'h100, 0, 2'b00, 0, 0, 0,            2'b00, 0, 0,      0, 0, 0, 0, 0);
      vecs[1]  = mk(1, 2'b00, 32'h100, 0, 2'b00, 0, 0, 0,            2'b01, 1, 32'h100, 0, 0, 0, 0, 0);
      vecs[2]  = mk(1, 2'b00, 32'h100, 0, 2'b00, 0, 0, 0,            2'b01, 1, 32'h100, 0, 0, 0, 0, 0);
      vecs[3]  = mk(1, 2'b00, 32'h100, 0, 2'b00, 0, 0, 0,            2'b01, 1, 32'h100, 0, 0, 0, 0, 0);
      vecs[4]  = mk(1, 2'b00, 32'h100, 0, 2'b00, 0, 1, 32'hDEADBEEF, 2'b01, 1, 32'h100, 32'hDEADBEEF, 1, 0, 0, 0);
      vecs[5]  = mk(0, 2'b00, 0,       0, 2'b00, 0, 1, 32'h5555,     2'b00, 0, 0,      0, 0, 0, 0, 0);
      vecs[6]  = mk(0, 2'b00, 0,       0, 2'b00, 0, 1, 32'h6666,     2'b00, 0, 0,      0, 0, 0, 0, 0);
      // dcache line fill, address held despite requester change
      vecs[7]  = mk(0, 2'b00, 0, 1, 2'b10, 32'h208, 0, 0,            2'b00, 0, 0,      0, 0, 0, 0, 0);
      vecs[8]  = mk(0, 2'b00, 0, 1, 2'b10, 32'h208, 0, 0,            2'b10, 1, 32'h208, 0, 0, 0, 0, 0);
      vecs[9]  = mk(0, 2'b00, 0, 1, 2'b10, 32'h208, 1, 32'h11111111, 2'b10, 1, 32'h208, 0, 0, 32'h11111111, 1, 0);
      vecs[10] = mk(0, 2'b00, 0, 1, 2'b10, 32'h999, 0, 0,            2'b10, 1, 32'h208, 0, 0, 0, 0, 0);
      vecs[11] = mk(0, 2'b00, 0, 1, 2'b10, 32'h208, 1, 32'h22222222, 2'b10, 1, 32'h208, 0, 0, 32'h22222222, 1, 0);
      vecs[12] = mk(0, 2'b00, 0, 0, 2'b00, 0,       0, 0,            2'b00, 0, 0,      0, 0, 0, 0, 0);
      vecs[13] = mk(0, 2'b00, 0, 0, 2'b00, 0,       0, 0,            2'b00, 0, 0,      0, 0, 0, 0, 0);
      // simultaneous request after dcache owned last: icache first, dcache after turnaround
      vecs[14] = mk(1, 2'b00, 32'h300, 1, 2'b00, 32'h400, 0, 0,      2'b00, 0, 0,      0, 0, 0, 0, 0);
      vecs[15] = mk(1, 2'b00, 32'h300, 1, 2'b00, 32'h400, 0, 0,      2'b01, 1, 32'h300, 0, 0, 0, 0, 0);
      vecs[16] = mk(1, 2'b00, 32'h300, 1, 2'b00, 32'h400, 1, 32'hA,  2'b01, 1, 32'h300, 32'hA, 1, 0, 0, 0);
      vecs[17] = mk(0, 2'b00, 0,       1, 2'b00, 32'h400, 0, 0,      2'b00, 0, 0,      0, 0, 0, 0, 0);
      vecs[18] = mk(0, 2'b00, 0,       1, 2'b00, 32'h400, 0, 0,      2'b00, 0, 0,      0, 0, 0, 0, 0);
      vecs[19] = mk(0, 2'b00, 0,       1, 2'b00, 32'h400, 0, 0,      2'b10, 1, 32'h400, 0, 0, 0, 0, 0);
      vecs[20] = mk(0, 2'b00, 0,       1, 2'b00, 32'h400, 1, 32'hB,  2'b10, 1, 32'h400, 0, 0, 32'hB, 1, 0);
      vecs[21] = mk(0, 2'b00, 0,       0, 2'b00, 0,       0, 0,      2'b00, 0, 0,      0, 0, 0, 0, 0);
      vecs[22] = mk(0, 2'b00, 0,       0, 2'b00, 0,       0, 0,      2'b00, 0, 0,      0, 0, 0, 0, 0);

      repeat (2) @(posedge clk);
      #1;
      chk("rst_grant", 64'(grant), 64'(2'b00));
      chk("rst_mem_req", 64'(mem_req), 64'h0);
      chk("rst_icache_resp", 64'(icache_resp), 64'h0);
      chk("rst_dcache_resp", 64'(dcache_resp), 64'h0);
      chk("rst_timeout", 64'(timeout), 64'h0);
      rst = 1'b0;

      for (int i = 0; i < 23; i++) begin
         next();
         drive(vecs[i].ic_v, vecs[i].ic_op, vecs[i].ic_addr,
               vecs[i].dc_v, vecs[i].dc_op, vecs[i].dc_addr, vecs[i].rdy, vecs[i].rdata);
         @(negedge clk);
         chk($sformatf("v%0d_grant", i), 64'(grant), 64'(vecs[i].e_grant));
         chk($sformatf("v%0d_mem_valid", i), 64'(mem_req.valid), 64'(vecs[i].e_mv));
         if (vecs[i].e_mv)
            chk($sformatf("v%0d_mem_addr", i), 64'(mem_req.addr), 64'(vecs[i].e_maddr));
         chk($sformatf("v%0d_icache_resp", i), 64'(icache_resp), 64'(mkr(vecs[i].e_icd, vecs[i].e_icr)));
         chk($sformatf("v%0d_dcache_resp", i), 64'(dcache_resp), 64'(mkr(vecs[i].e_dcd, vecs[i].e_dcr)));
         chk($sformatf("v%0d_timeout", i), 64'(timeout), 64'(vecs[i].e_to));
      end

      // four contended rounds alternate, starting with icache since dcache owned last
      for (int r = 0; r < 4; r++) begin
         exp_g = (r % 2 == 0) ? 2'b01 : 2'b10;
         next();
         drive(1, 2'b00, 32'h700 + 32'(r), 1, 2'b00, 32'h800 + 32'(r), 0, 0);
         @(negedge clk);
         chk($sformatf("rr%0d_idle", r), 64'(grant), 64'(2'b00));
         next();
         @(negedge clk);
         chk($sformatf("rr%0d_grant", r), 64'(grant), 64'(exp_g));
         next();
         mem_resp = mkr(32'hC0 + 32'(r), 1'b1);
         #1;
         if (exp_g == 2'b01)
            chk($sformatf("rr%0d_resp", r), 64'(icache_resp), 64'(mkr(32'hC0 + 32'(r), 1'b1)));
         else
            chk($sformatf("rr%0d_resp", r), 64'(dcache_resp), 64'(mkr(32'hC0 + 32'(r), 1'b1)));
         next();
         drive(0, 2'b00, 0, 0, 2'b00, 0, 0, 0);
         @(negedge clk);
         chk($sformatf("rr%0d_done", r), 64'(grant), 64'(2'b00));
         next();
      end

      // timeout: icache owns, memory never answers
      next();
      drive(1, 2'b00, 32'h500, 0, 2'b00, 0, 0, 0);
      @(negedge clk);
      chk("to_idle", 64'(grant), 64'(2'b00));
      n = 0; found = 0; bad = 0;
      while (n < 300 && !found) begin
         next();
         @(negedge clk);
         n++;
         if (timeout) found = 1;
         else if (grant != 2'b01) bad = 1;
      end
      chk("to_seen", 64'(found), 64'(1));
      chk("to_busy_cycles", 64'(n), 64'(256));
      chk("to_grant_held", 64'(bad), 64'(0));
      chk("to_icache_resp", 64'(icache_resp), 64'(mkr(32'h0, 1'b1)));
      chk("to_dcache_resp", 64'(dcache_resp), 64'h0);
      next();
      drive(0, 2'b00, 0, 0, 2'b00, 0, 1, 32'h77);
      @(negedge clk);
      chk("to_done_grant", 64'(grant), 64'(2'b00));
      chk("to_done_timeout", 64'(timeout), 64'h0);
      chk("to_done_mem_valid", 64'(mem_req.valid), 64'h0);
      chk("to_done_icache_resp", 64'(icache_resp), 64'h0);
      chk("to_done_dcache_resp", 64'(dcache_resp), 64'h0);
      next();
      mem_resp = mkr(0, 1'b0);
      @(negedge clk);
      chk("to_idle_after", 64'(grant), 64'(2'b00));

      // async reset mid line fill after first beat
      next();
      drive(1, 2'b10, 32'h600, 0, 2'b00, 0, 0, 0);
      next();
      @(negedge clk);
      chk("rst_mid_grant", 64'(grant), 64'(2'b01));
      next();
      mem_resp = mkr(32'h1, 1'b1);
      @(negedge clk);
      chk("rst_mid_beat1", 64'(icache_resp), 64'(mkr(32'h1, 1'b1)));
      next();
      mem_resp = mkr(0, 1'b0);
      next();
      #1;
      mem_resp = mkr(32'h99, 1'b1);
      #1;
      rst = 1'b1;
      #1;
      chk("rst_async_grant", 64'(grant), 64'(2'b00));
      chk("rst_async_mem_valid", 64'(mem_req.valid), 64'h0);
      chk("rst_async_icache_resp", 64'(icache_resp), 64'h0);
      chk("rst_async_dcache_resp", 64'(dcache_resp), 64'h0);
      @(negedge clk);
      rst = 1'b0;
      drive(0, 2'b00, 0, 0, 2'b00, 0, 0, 0);
      next();
      drive(1, 2'b00, 32'h900, 1, 2'b00, 32'hA00, 0, 0);
      @(negedge clk);
      chk("post_rst_idle", 64'(grant), 64'(2'b00));
      next();
      @(negedge clk);
      chk("post_rst_grant", 64'(grant), 64'(2'b01));
      chk("post_rst_addr", 64'(mem_req.addr), 64'(32'h900));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
